// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect, fetch gate and decode handshake.
// The master side is the fetch unit; the slave side is memory plus decode.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic              fetch_en;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd_en;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_word;
    logic [DATA_W-1:0] instr_imm;
    logic [ADDR_W-1:0] instr_pc;
    logic              stall;

    modport master (
        input  fetch_en, imem_rdata, redirect_en, redirect_pc, stall,
        output imem_addr, imem_rd_en, instr_valid, instr_word, instr_imm, instr_pc
    );

    modport slave (
        output fetch_en, imem_rdata, redirect_en, redirect_pc, stall,
        input  imem_addr, imem_rd_en, instr_valid, instr_word, instr_imm, instr_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Two-word instruction fetch stage: reads opcode and immediate words from synchronous memory
// and hands the assembled instruction to decode through a valid/stall handshake.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_fetch_unit_if.master    bus
);

    typedef enum logic [1:0] {REQ_HI, REQ_LO, CAP, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              rd_en_c;
    logic [ADDR_W-1:0] addr_c;
    logic              load_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= REQ_HI;
            pc_q    <= ADDR_W'(RESET_PC);
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
            imm_q   <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            imm_q   <= imm_d;
            ipc_q   <= ipc_d;
        end
    end

    // Next-state, memory request and output-register load
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        valid_d = valid_q;
        word_d  = word_q;
        imm_d   = imm_q;
        ipc_d   = ipc_q;
        rd_en_c = 1'b0;
        addr_c  = pc_q;
        load_c  = 1'b0;

        case (state_q)
            REQ_HI: begin
                if (bus.fetch_en) begin
                    rd_en_c = 1'b1;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                addr_c  = pc_q + ADDR_W'(1);
                rd_en_c = 1'b1;
                hi_d    = bus.imem_rdata;
                state_d = CAP;
            end
            CAP: begin
                lo_d    = bus.imem_rdata;
                state_d = ISSUE;
            end
            ISSUE: begin
                load_c = (!valid_q || !bus.stall) && !bus.redirect_en;
            end
            default: state_d = REQ_HI;
        endcase

        if (load_c) begin
            word_d  = hi_q;
            imm_d   = lo_q;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(2);
            state_d = REQ_HI;
        end else if (valid_q && !bus.stall) begin
            valid_d = 1'b0;
        end

        // Redirect drops the in-flight fetch and any instruction not yet taken by decode
        if (bus.redirect_en) begin
            pc_d    = bus.redirect_pc & ~ADDR_W'(1);
            state_d = REQ_HI;
            valid_d = 1'b0;
        end
    end

    assign bus.imem_addr   = addr_c;
    assign bus.imem_rd_en  = rd_en_c && reset;
    assign bus.instr_valid = valid_q;
    assign bus.instr_word  = word_q;
    assign bus.instr_imm   = imm_q;
    assign bus.instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a cycle-count reference model.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam logic [ADDR_W-1:0] RST_PC = 20'd32;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sparse memory: explicit words where a test needs them, an address hash elsewhere
    logic [DATA_W-1:0] ovr [logic [ADDR_W-1:0]];

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (ovr.exists(a)) return ovr[a];
        return 16'((a * 20'd40503) ^ (a >> 4));
    endfunction

    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rdata <= mem_rd(bus.imem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: words requested so far for the next instruction (0..3), its fetch pc,
    // and the instruction decode should currently be seeing.
    int                m_words;
    bit                m_init;
    logic              m_valid;
    logic [DATA_W-1:0] m_word, m_imm;
    logic [ADDR_W-1:0] m_pc, m_fpc;

    initial begin
        m_init  = 1'b0;
        m_words = 0;
        m_valid = 1'b0;
        m_word  = '0;
        m_imm   = '0;
        m_pc    = '0;
        m_fpc   = RST_PC;
    end

    always @(negedge clk) begin
        logic              exp_rd;
        logic              ld;
        logic [ADDR_W-1:0] exp_addr;
        if (m_init) begin
            chk("valid", 32'(bus.instr_valid), 32'(m_valid));
            if (m_valid) begin
                chk("word", 32'(bus.instr_word), 32'(m_word));
                chk("imm",  32'(bus.instr_imm),  32'(m_imm));
                chk("pc",   32'(bus.instr_pc),   32'(m_pc));
            end
            exp_rd = reset && ((m_words == 0 && bus.fetch_en) || m_words == 1);
            chk("rd_en", 32'(bus.imem_rd_en), 32'(exp_rd));
            if (exp_rd) begin
                exp_addr = (m_words == 0) ? m_fpc : m_fpc + 20'd1;
                chk("addr", 32'(bus.imem_addr), 32'(exp_addr));
            end
        end
        // Effect of the coming rising edge
        if (!reset) begin
            m_init  = 1'b1;
            m_valid = 1'b0;
            m_fpc   = RST_PC;
            m_words = 0;
        end else if (m_init) begin
            if (bus.redirect_en) begin
                m_fpc   = bus.redirect_pc & 20'hFFFFE;
                m_words = 0;
                m_valid = 1'b0;
            end else begin
                ld = 1'b0;
                if (m_words == 0) begin
                    if (bus.fetch_en) m_words = 1;
                end else if (m_words < 3) begin
                    m_words++;
                end else if (!m_valid || !bus.stall) begin
                    ld      = 1'b1;
                    m_word  = mem_rd(m_fpc);
                    m_imm   = mem_rd(m_fpc + 20'd1);
                    m_pc    = m_fpc;
                    m_fpc   = m_fpc + 20'd2;
                    m_words = 0;
                end
                if (ld) m_valid = 1'b1;
                else if (m_valid && !bus.stall) m_valid = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic fe);
        reset = 1'b0;
        bus.fetch_en = fe;
        tick(1);
        reset = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ovr[20'd32]    = 16'hA100;
        ovr[20'd33]    = 16'h0000;
        ovr[20'd34]    = 16'hA200;
        ovr[20'd35]    = 16'h0002;
        ovr[20'hFFFFE] = 16'h1234;
        ovr[20'hFFFFF] = 16'h5678;

        reset           = 1'b0;
        bus.fetch_en    = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        tick(3);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_word",  32'(bus.instr_word),  32'd0);
        chk("rst_imm",   32'(bus.instr_imm),   32'd0);
        chk("rst_pc",    32'(bus.instr_pc),    32'd0);
        chk("rst_rd_en", 32'(bus.imem_rd_en),  32'd0);

        // Basic fetch: first instruction on the 4th edge, next one 4 edges later
        reset = 1'b1;
        tick(4);
        chk("b1_valid", 32'(bus.instr_valid), 32'd1);
        chk("b1_word",  32'(bus.instr_word),  32'hA100);
        chk("b1_imm",   32'(bus.instr_imm),   32'h0000);
        chk("b1_pc",    32'(bus.instr_pc),    32'd32);
        tick(4);
        chk("b2_valid", 32'(bus.instr_valid), 32'd1);
        chk("b2_word",  32'(bus.instr_word),  32'hA200);
        chk("b2_imm",   32'(bus.instr_imm),   32'h0002);
        chk("b2_pc",    32'(bus.instr_pc),    32'd34);

        // Stall hold, then release
        restart(1'b1);
        tick(4);
        bus.stall = 1'b1;
        tick(6);
        chk("st_valid", 32'(bus.instr_valid), 32'd1);
        chk("st_word",  32'(bus.instr_word),  32'hA100);
        chk("st_pc",    32'(bus.instr_pc),    32'd32);
        chk("st_rd_en", 32'(bus.imem_rd_en),  32'd0);
        bus.stall = 1'b0;
        tick(1);
        chk("st_rel_word", 32'(bus.instr_word), 32'hA200);
        chk("st_rel_pc",   32'(bus.instr_pc),   32'd34);

        // Redirect while the word at 34 is being requested
        restart(1'b1);
        tick(5);
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 20'd41;
        tick(1);
        bus.redirect_en = 1'b0;
        #1;
        chk("rd_valid", 32'(bus.instr_valid), 32'd0);
        chk("rd_addr",  32'(bus.imem_addr),   32'd40);
        chk("rd_rd_en", 32'(bus.imem_rd_en),  32'd1);
        tick(4);
        chk("rd_pc",    32'(bus.instr_pc),    32'd40);
        chk("rd_ivld",  32'(bus.instr_valid), 32'd1);

        // fetch_en gating and dropping it mid-instruction
        restart(1'b0);
        repeat (10) begin
            tick(1);
            chk("fe_rd_en", 32'(bus.imem_rd_en),  32'd0);
            chk("fe_valid", 32'(bus.instr_valid), 32'd0);
        end
        bus.fetch_en = 1'b1;
        tick(2);
        bus.fetch_en = 1'b0;
        tick(2);
        chk("fe_issue_valid", 32'(bus.instr_valid), 32'd1);
        chk("fe_issue_pc",    32'(bus.instr_pc),    32'd32);
        tick(8);
        chk("fe_halt_rd_en", 32'(bus.imem_rd_en),  32'd0);
        chk("fe_halt_valid", 32'(bus.instr_valid), 32'd0);

        // Wrap at the top of the address space
        bus.fetch_en    = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 20'hFFFFE;
        tick(1);
        bus.redirect_en = 1'b0;
        tick(4);
        chk("wr_word", 32'(bus.instr_word), 32'h1234);
        chk("wr_imm",  32'(bus.instr_imm),  32'h5678);
        chk("wr_pc",   32'(bus.instr_pc),   32'hFFFFE);
        #1;
        chk("wr_next_addr", 32'(bus.imem_addr), 32'd0);

        // Reset while an instruction waits on a stalled decode
        bus.stall = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rm_valid", 32'(bus.instr_valid), 32'd0);
        chk("rm_word",  32'(bus.instr_word),  32'd0);
        reset     = 1'b1;
        bus.stall = 1'b0;
        #1;
        chk("rm_addr", 32'(bus.imem_addr), 32'd32);
        tick(4);
        chk("rm_pc",   32'(bus.instr_pc),  32'd32);

        // Random traffic against the model
        repeat (3000) begin
            reset           = ($urandom_range(0, 99) != 0);
            bus.fetch_en    = ($urandom_range(0, 99) < 85);
            bus.stall       = ($urandom_range(0, 99) < 30);
            bus.redirect_en = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0)
                bus.redirect_pc = 20'hFFFF0 + 20'($urandom_range(0, 15));
            else
                bus.redirect_pc = 20'($urandom);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the decode/controller.
- Reads the two-word (32-bit) instruction format from the synchronous-read instruction memory: an opcode word at an even address, then an immediate word at address+1.
- Presents each assembled instruction, with its PC, to decode through a valid/stall handshake.
- Supports a redirect (branch/jump/reset vector) and a fetch-enable gate, so memory loading and execution are mutually exclusive.

Parameters:
ADDR_W, 20, instruction memory address width (word addressed)
DATA_W, 16, instruction memory word width
RESET_PC, 32, PC loaded on reset; must be even

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clk
fetch_en  input  1  1 = fetch may start new instructions
imem_addr  output  ADDR_W  instruction memory read address
imem_rd_en  output  1  read strobe; imem_rdata valid the cycle after
imem_rdata  input  DATA_W  read data, 1-cycle latency after imem_rd_en
redirect_en  input  1  load new PC, discard in-flight fetch
redirect_pc  input  ADDR_W  redirect target; bit 0 ignored (forced 0)
instr_valid  output  1  instr_word/instr_imm/instr_pc hold a valid instruction
instr_word  output  DATA_W  opcode word (mem[pc])
instr_imm  output  DATA_W  immediate word (mem[pc+1])
instr_pc  output  ADDR_W  address of instr_word
stall  input  1  decode cannot accept; output registers must hold

Behaviour:
- Reset (reset==0 at edge):
  - pc=RESET_PC, state=REQ_HI.
  - instr_valid=0; instr_word, instr_imm and instr_pc=0; hi/lo staging regs=0.
  - imem_rd_en forced 0 while reset is low.
- FSM states: REQ_HI, REQ_LO, CAP, ISSUE.
  - REQ_HI:
    - If fetch_en=1: imem_addr=pc, imem_rd_en=1, go to REQ_LO.
    - Else: imem_rd_en=0, stay.
  - REQ_LO: imem_addr=pc+1, imem_rd_en=1; hi_reg<=imem_rdata; go to CAP.
  - CAP: imem_rd_en=0; lo_reg<=imem_rdata; go to ISSUE.
  - ISSUE:
    - If (!instr_valid || !stall): instr_word<=hi_reg, instr_imm<=lo_reg, instr_pc<=pc, instr_valid<=1, pc<=pc+2, go to REQ_HI.
    - Else: stay, no memory request.
- imem_addr in non-request states: holds pc; value is don't-care to memory.
- Output handshake:
  - A transfer occurs on an edge where instr_valid=1 and stall=0.
  - After a transfer with no new load on the same edge, instr_valid<=0.
  - While instr_valid=1 and stall=1, all instr_* outputs are stable.
- Latency: first instr_valid=1 on the 4th rising edge after the first edge with reset=1 and fetch_en=1. Steady state is one instruction per 4 cycles with stall=0.
- Redirect:
  - redirect_en=1 at an edge (reset high): pc<={redirect_pc[ADDR_W-1:1],0}, state<=REQ_HI, instr_valid<=0.
  - Staged hi/lo are discarded.
  - Redirect has priority over ISSUE loading and over stall.
  - Reset has priority over redirect.
- fetch_en:
  - Sampled only in REQ_HI.
  - Dropping it mid-instruction does not abort; the current instruction completes through ISSUE, then fetch halts at REQ_HI.
- PC arithmetic: modulo 2^ADDR_W. pc=2^ADDR_W-2 fetches words 0xFFFFE and 0xFFFFF, then wraps to 0.
- Reset mid-operation: any state → REQ_HI with outputs cleared on that edge. The pending instruction is lost.

Test Plan:
- Basic fetch: mem[32]=16'hA100, mem[33]=16'h0000, mem[34]=16'hA200, mem[35]=16'h0002; release reset with fetch_en=1, stall=0 → imem_addr sequence 32,33,–,–,34,35. First output is instr_word=A100, imm=0000, pc=32 with instr_valid asserted on the 4th edge. Next output is A200/0002/pc=34, 4 cycles later.
- Stall hold: hold stall=1 for 6 cycles while the pc=32 instruction is valid → outputs unchanged, no imem_rd_en after the second instruction is staged. Release stall → second instruction appears on the next edge.
- Redirect: redirect_en=1, redirect_pc=20'd41 during REQ_LO → next cycle REQ_HI with imem_addr=40, instr_valid=0; the staged word from 34 is never issued.
- fetch_en gating: fetch_en=0 after reset → imem_rd_en stays 0 for 10 cycles and instr_valid=0. Drop fetch_en during CAP → that instruction still issues, then no further reads.
- Wrap: redirect to 20'hFFFFE, mem[FFFFE]=16'h1234, mem[FFFFF]=16'h5678 → output 1234/5678/pc=FFFFE, then next imem_addr=0.
- Reset mid-op: reset=0 for one edge while in ISSUE with stall=1 → instr_valid=0, pc=32 next cycle, fetch restarts at 32.
